// File: rtl/audio_in_sched_pkg.sv
// Shared types and helpers for the audio input drain scheduler.
package audio_in_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        WAIT = 3'd2,
        CAPT = 3'd3,
        EMIT = 3'd4
    } drain_state_t;

    // Mono channels per stereo pair.
    localparam int STEREO_MULTIPLIER = 2;

    // Width of the flat channel index; never narrower than one bit.
    function automatic int chan_idx_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter with synchronous clear. A clear coincident with
// an event leaves the count at 1 so the event is never lost.
module sat_event_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             evt,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins over hold, an event in the clear cycle counts once.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = evt ? WIDTH'(1) : '0;
        end else if (evt && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/audio_in_drain_sched.sv
// Drain scheduler: pops one stereo frame at a time from the I2S input buffer,
// captures it after the buffer read latency and serialises its mono channels
// onto a valid/ready stream. Also counts buffer-full episodes.
//
// Stream handshake: a beat transfers on a rising sys_clk edge where m_valid and
// m_ready are both high. Once m_valid is raised, m_data/m_chan/m_last hold until
// that transfer and m_valid stays high; only reset removes it early.
module audio_in_drain_sched
    import audio_in_sched_pkg::*;
#(
    parameter int NUM_AUDIO_CHANNELS = 1,
    parameter int AUDIO_WIDTH        = 24,
    parameter int READ_LATENCY       = 1,
    parameter int OVF_CNT_WIDTH      = 16,
    localparam int TOTAL             = NUM_AUDIO_CHANNELS * STEREO_MULTIPLIER,
    localparam int CHAN_W            = chan_idx_width(TOTAL)
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           en,
    input  logic                           buffer_ready,
    input  logic                           buffer_full,
    input  logic [TOTAL*AUDIO_WIDTH-1:0]   audio_channel_in,
    output logic                           adv_read_enable,
    output logic [AUDIO_WIDTH-1:0]         m_data,
    output logic [CHAN_W-1:0]              m_chan,
    output logic                           m_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           busy,
    input  logic                           clr_overflow,
    output logic [OVF_CNT_WIDTH-1:0]       overflow_cnt
);

    drain_state_t                 state_q, state_d;
    logic [TOTAL*AUDIO_WIDTH-1:0] frame_q;
    logic [CHAN_W-1:0]            idx_q, idx_d;
    logic [2:0]                   lat_q, lat_d;
    logic                         adv_q;
    logic                         capture;
    logic                         last_chan;
    logic                         emit;
    logic                         full_prev_q;
    logic                         full_rise;

    assign emit      = (state_q == EMIT);
    assign last_chan = (idx_q == CHAN_W'(TOTAL - 1));

    // Next-state logic: one pop, wait out the read latency, capture, then emit
    // every channel; chain straight into the next pop when more data is ready.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && buffer_ready) begin
                    state_d = POP;
                end
            end
            POP: begin
                lat_d   = 3'(READ_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q <= 3'd1) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                capture = 1'b1;
                idx_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                if (m_ready) begin
                    if (!last_chan) begin
                        idx_d = idx_q + CHAN_W'(1);
                    end else if (en && buffer_ready) begin
                        state_d = POP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; the pop pulse is registered so it is high exactly
    // for the cycle spent in POP.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lat_q   <= '0;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            adv_q   <= (state_d == POP);
        end
    end

    // Frame register, loaded with all channels of the popped frame at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_q <= '0;
        end else if (capture) begin
            frame_q <= audio_channel_in;
        end
    end

    // Stream outputs: select the current channel, all zero outside EMIT.
    always_comb begin
        m_data = '0;
        for (int i = 0; i < TOTAL; i++) begin
            if (emit && (idx_q == CHAN_W'(i))) begin
                m_data = frame_q[i*AUDIO_WIDTH +: AUDIO_WIDTH];
            end
        end
    end

    assign m_valid         = emit;
    assign m_chan          = emit ? idx_q : '0;
    assign m_last          = emit && last_chan;
    assign busy            = (state_q != IDLE);
    assign adv_read_enable = adv_q;

    // Previous buffer_full value for rising-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            full_prev_q <= 1'b0;
        end else begin
            full_prev_q <= buffer_full;
        end
    end

    assign full_rise = buffer_full && !full_prev_q;

    sat_event_counter #(
        .WIDTH(OVF_CNT_WIDTH)
    ) u_ovf_cnt (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .evt    (full_rise),
        .clr    (clr_overflow),
        .cnt    (overflow_cnt)
    );

endmodule

// File: tb/tb_audio_in_drain_sched.sv
// Directed bench for audio_in_drain_sched. Instance a: one stereo pair,
// READ_LATENCY=1, 16-bit overflow counter. Instance b: two stereo pairs,
// READ_LATENCY=2, 2-bit overflow counter.
module tb_audio_in_drain_sched;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance a signals
    logic        a_en, a_br, a_bf, a_ready, a_clr;
    logic [47:0] a_in;
    logic        a_adv, a_last, a_valid, a_busy;
    logic [23:0] a_data;
    logic [0:0]  a_chan;
    logic [15:0] a_ovf;

    // Instance b signals
    logic        b_en, b_br, b_bf, b_ready, b_clr;
    logic [95:0] b_in;
    logic        b_adv, b_last, b_valid, b_busy;
    logic [23:0] b_data;
    logic [1:0]  b_chan;
    logic [1:0]  b_ovf;

    int checks   = 0;
    int failures = 0;

    // Event counters for instance a, sampled mid-cycle.
    int a_pops  = 0;
    int a_beats = 0;
    int cyc     = 0;
    int adv_t[$];

    audio_in_drain_sched #(
        .NUM_AUDIO_CHANNELS(1), .AUDIO_WIDTH(24), .READ_LATENCY(1), .OVF_CNT_WIDTH(16)
    ) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(a_en), .buffer_ready(a_br),
        .buffer_full(a_bf), .audio_channel_in(a_in), .adv_read_enable(a_adv),
        .m_data(a_data), .m_chan(a_chan), .m_last(a_last), .m_valid(a_valid),
        .m_ready(a_ready), .busy(a_busy), .clr_overflow(a_clr), .overflow_cnt(a_ovf)
    );

    audio_in_drain_sched #(
        .NUM_AUDIO_CHANNELS(2), .AUDIO_WIDTH(24), .READ_LATENCY(2), .OVF_CNT_WIDTH(2)
    ) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(b_en), .buffer_ready(b_br),
        .buffer_full(b_bf), .audio_channel_in(b_in), .adv_read_enable(b_adv),
        .m_data(b_data), .m_chan(b_chan), .m_last(b_last), .m_valid(b_valid),
        .m_ready(b_ready), .busy(b_busy), .clr_overflow(b_clr), .overflow_cnt(b_ovf)
    );

    always @(negedge clk) begin
        cyc++;
        if (a_adv) begin
            a_pops++;
            adv_t.push_back(cyc);
        end
        if (a_valid && a_ready) a_beats++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_en = 0; a_br = 0; a_bf = 0; a_ready = 0; a_clr = 0; a_in = '0;
        b_en = 0; b_br = 0; b_bf = 0; b_ready = 0; b_clr = 0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_adv, a_valid, a_last, a_busy, a_chan, a_data, a_ovf} !== '0) begin
            failures++;
            $display("FAIL reset_a: adv=%0b valid=%0b last=%0b busy=%0b chan=%0d data=%h ovf=%0d expected all 0",
                     a_adv, a_valid, a_last, a_busy, a_chan, a_data, a_ovf);
        end
        checks++;
        if ({b_adv, b_valid, b_last, b_busy, b_chan, b_data, b_ovf} !== '0) begin
            failures++;
            $display("FAIL reset_b: adv=%0b valid=%0b busy=%0b chan=%0d data=%h ovf=%0d expected all 0",
                     b_adv, b_valid, b_busy, b_chan, b_data, b_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int p0, b0;
        a_in = {24'hABCDEF, 24'h123456};
        a_en = 1; a_ready = 1; a_br = 1;
        p0 = a_pops; b0 = a_beats;
        tick();
        a_br = 0;
        checks++;
        if (!(a_adv === 1'b1 && a_busy === 1'b1)) begin
            failures++;
            $display("FAIL single_pop: adv=%0b busy=%0b expected 1 1", a_adv, a_busy);
        end
        tick();
        tick();
        checks++;
        if (a_adv !== 1'b0 || a_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early: adv=%0b valid=%0b expected 0 0", a_adv, a_valid);
        end
        tick();
        checks++;
        if ({a_valid, a_data, a_chan, a_last} !== {1'b1, 24'h123456, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_beat0: valid=%0b data=%h chan=%0d last=%0b expected 1 123456 0 0",
                     a_valid, a_data, a_chan, a_last);
        end
        tick();
        checks++;
        if ({a_valid, a_data, a_chan, a_last} !== {1'b1, 24'hABCDEF, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL single_beat1: valid=%0b data=%h chan=%0d last=%0b expected 1 abcdef 1 1",
                     a_valid, a_data, a_chan, a_last);
        end
        tick();
        checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: valid=%0b busy=%0b expected 0 0", a_valid, a_busy);
        end
        checks++;
        if ((a_pops - p0) != 1 || (a_beats - b0) != 2) begin
            failures++;
            $display("FAIL single_counts: pops=%0d beats=%0d expected 1 2", a_pops - p0, a_beats - b0);
        end
    endtask

    task automatic test_stall();
        int  k;
        bit  ph;
        logic [23:0] exp_d;
        for (int i = 0; i < 4; i++) b_in[i*24 +: 24] = 24'hA00000 + 24'(i);
        b_en = 1; b_ready = 0; b_br = 1;
        tick();
        b_br = 0;
        for (int c = 0; c < 20 && !b_valid; c++) tick();
        checks++;
        if (b_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_start: valid=%0b expected 1 within bound", b_valid);
        end
        k = 0; ph = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            exp_d = 24'hA00000 + 24'(k);
            checks++;
            if ({b_valid, b_data, b_chan, b_last} !== {1'b1, exp_d, 2'(k), (k == 3)}) begin
                failures++;
                $display("FAIL stall_beat%0d: valid=%0b data=%h chan=%0d last=%0b expected 1 %h %0d %0b",
                         k, b_valid, b_data, b_chan, b_last, exp_d, k, (k == 3));
            end
            b_ready = ph;
            if (ph) k++;
            ph = ~ph;
            tick();
        end
        b_ready = 0;
        checks++;
        if (k != 4 || b_valid !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_end: beats=%0d valid=%0b busy=%0b expected 4 0 0", k, b_valid, b_busy);
        end
    endtask

    task automatic test_back_to_back();
        int n, b0;
        adv_t.delete();
        b0 = a_beats;
        a_in = {24'h0BBBBB, 24'h0AAAAA};
        a_en = 1; a_ready = 1; a_br = 1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (a_adv) begin
                n++;
                if (n == 3) a_br = 0;
            end
        end
        checks++;
        if (adv_t.size() != 3) begin
            failures++;
            $display("FAIL b2b_pops: pops=%0d expected 3", adv_t.size());
        end else begin
            checks++;
            if ((adv_t[1] - adv_t[0]) != 5 || (adv_t[2] - adv_t[1]) != 5) begin
                failures++;
                $display("FAIL b2b_spacing: gaps=%0d,%0d expected 5,5",
                         adv_t[1] - adv_t[0], adv_t[2] - adv_t[1]);
            end
        end
        checks++;
        if ((a_beats - b0) != 6 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_beats: beats=%0d busy=%0b expected 6 0", a_beats - b0, a_busy);
        end
    endtask

    task automatic test_enable();
        int p0, b0;
        a_en = 1; a_ready = 1; a_br = 1;
        p0 = a_pops; b0 = a_beats;
        tick();
        tick();
        a_en = 0;
        repeat (15) tick();
        checks++;
        if ((a_pops - p0) != 1 || (a_beats - b0) != 2 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL en_drop: pops=%0d beats=%0d busy=%0b expected 1 2 0",
                     a_pops - p0, a_beats - b0, a_busy);
        end
        a_en = 1;
        tick();
        checks++;
        if (a_adv !== 1'b1) begin
            failures++;
            $display("FAIL en_restart: adv=%0b expected 1", a_adv);
        end
        a_br = 0;
        repeat (10) tick();
        checks++;
        if (a_busy !== 1'b0) begin
            failures++;
            $display("FAIL en_drain: busy=%0b expected 0", a_busy);
        end
    endtask

    task automatic test_overflow();
        a_en = 0;
        for (int i = 0; i < 3; i++) begin
            a_bf = 1; tick();
            a_bf = 0; tick();
        end
        checks++;
        if (a_ovf !== 16'd3) begin
            failures++;
            $display("FAIL ovf_three: cnt=%0d expected 3", a_ovf);
        end
        a_bf = 1; a_clr = 1;
        tick();
        a_clr = 0;
        checks++;
        if (a_ovf !== 16'd1) begin
            failures++;
            $display("FAIL ovf_clr_edge: cnt=%0d expected 1", a_ovf);
        end
        a_bf = 0; tick();
        a_bf = 1; tick();
        a_clr = 1; tick();
        a_clr = 0; a_bf = 0; tick();
        checks++;
        if (a_ovf !== 16'd0) begin
            failures++;
            $display("FAIL ovf_clr_level: cnt=%0d expected 0", a_ovf);
        end
        for (int i = 0; i < 5; i++) begin
            b_bf = 1; tick();
            b_bf = 0; tick();
        end
        checks++;
        if (b_ovf !== 2'd3) begin
            failures++;
            $display("FAIL ovf_saturate: cnt=%0d expected 3", b_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        a_in = {24'hABCDEF, 24'h123456};
        a_en = 1; a_br = 1; a_ready = 0;
        for (int c = 0; c < 12 && !a_valid; c++) tick();
        checks++;
        if ({a_valid, a_data, a_chan} !== {1'b1, 24'h123456, 1'b0}) begin
            failures++;
            $display("FAIL rst_pre: valid=%0b data=%h chan=%0d expected 1 123456 0", a_valid, a_data, a_chan);
        end
        a_ready = 1;
        tick();
        a_ready = 0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_adv, a_valid, a_last, a_busy, a_chan, a_data, a_ovf} !== '0) begin
            failures++;
            $display("FAIL rst_mid: adv=%0b valid=%0b last=%0b busy=%0b chan=%0d data=%h expected all 0",
                     a_adv, a_valid, a_last, a_busy, a_chan, a_data);
        end
        a_in = {24'h0FEDCB, 24'h654321};
        a_ready = 1;
        @(negedge clk);
        rst_n = 1'b1;
        b0 = a_beats;
        tick();
        for (int c = 0; c < 12 && !a_valid; c++) tick();
        checks++;
        if ({a_valid, a_data, a_chan} !== {1'b1, 24'h654321, 1'b0}) begin
            failures++;
            $display("FAIL rst_restart: valid=%0b data=%h chan=%0d expected 1 654321 0", a_valid, a_data, a_chan);
        end
        a_br = 0;
        repeat (10) tick();
        checks++;
        if ((a_beats - b0) != 2 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_drain: beats=%0d busy=%0b expected 2 0", a_beats - b0, a_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_enable();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
